hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clock port clk; one clock domain; all state on rising edge.
REQ-002 SHALL have reset port clear_n: asynchronous assert, active-low.
REQ-003 SHALL have inputs R1_addr[4:0] and R2_addr[4:0]: ID source register numbers.
REQ-004 SHALL have inputs use_r1 and use_r2: ID instruction reads that source.
REQ-005 SHALL have inputs Jump and JmpReg: ID-stage jump.
REQ-006 SHALL have input br_taken: EX-stage branch resolved taken.
REQ-007 SHALL have EX-stage inputs RegWrite2, MemRead2 and RW2[4:0].
REQ-008 SHALL have MEM-stage inputs RegWrite3, MemToReg3 and RW3[4:0].
REQ-009 SHALL have WB-stage inputs RegWrite4, MemToReg4 and RW4[4:0].
REQ-010 SHALL have inputs SysCall2 and halt_req; halt_req means the syscall code requests halt.
REQ-011 SHALL have asynchronous pushbutton inputs go and step.
REQ-012 SHALL have outputs Bypass1[1:0], Bypass2[1:0], Bypass3[1:0] and Bypass4[1:0], all combinational.
REQ-013 SHALL have outputs Bubble, Bubble_f and stall_pc (hold PC and IF/ID), all combinational.
REQ-014 SHALL have outputs NewHalt (1 = pipeline advances) and clear (synchronous pipeline clear).
REQ-015 SHALL have outputs stall_cnt[15:0], flush_cnt[15:0] and cycle_cnt[31:0].

Function
REQ-016 Bypass encoding SHALL be: 00 regfile, 01 MEM ALU result, 10 WB ALU result, 11 WB load data.
REQ-017 BypassN (N = 1 for R1, 2 for R2) SHALL be 01 when use_rN, RegWrite3, !MemToReg3, RW3 == RN_addr and RW3 != 0.
REQ-018 Otherwise BypassN SHALL be {1, MemToReg4} when use_rN, RegWrite4, RW4 == RN_addr and RW4 != 0; otherwise BypassN SHALL be 00.
REQ-019 A MEM-stage match SHALL take priority over a WB-stage match.
REQ-020 Bypass3 and Bypass4 SHALL be constant 00 (reserved).
REQ-021 Register 0 SHALL never forward and SHALL never stall.
REQ-022 Bubble SHALL be 1 on load-use: use_rN and a nonzero RN_addr matching either RW2 (RegWrite2 & MemRead2) or RW3 (RegWrite3 & MemToReg3).
REQ-023 Bubble_f SHALL equal br_taken | Jump | JmpReg.
REQ-024 stall_pc SHALL equal Bubble & !Bubble_f; on a simultaneous flush, the flush wins and the PC is redirected.
REQ-025 go and step SHALL each pass through a 2-flop synchronizer and rising-edge detector; a button pulse counts once.
REQ-026 The FSM SHALL have states INIT, RUN, HALT and STEP.
REQ-027 INIT SHALL assert clear for exactly 2 cycles after reset release, then go to RUN; NewHalt = 0 in INIT.
REQ-028 RUN SHALL drive NewHalt = 1 and SHALL go to HALT at the edge where SysCall2 & halt_req.
REQ-029 HALT SHALL drive NewHalt = 0; a go edge SHALL go to RUN, else a step edge SHALL go to STEP; go wins if both.
REQ-030 STEP SHALL drive NewHalt = 1 for exactly one cycle, then return to HALT (also when SysCall2 & halt_req).
REQ-031 While NewHalt = 0, Bubble, Bubble_f and stall_pc SHALL still be computed but SHALL NOT update counters.
REQ-032 stall_cnt SHALL increment on cycles with NewHalt & stall_pc, saturating at 0xFFFF.
REQ-033 flush_cnt SHALL increment on cycles with NewHalt & Bubble_f, saturating at 0xFFFF.
REQ-034 cycle_cnt SHALL increment on every NewHalt = 1 cycle and wrap modulo 2^32.

Reset
REQ-035 clear_n low SHALL immediately force state = INIT, clear = 1, NewHalt = 0, all counters 0 and synchronizer flops 0.
REQ-036 Reset asserted mid-HALT or mid-STEP SHALL abort that state; after release, the INIT sequence SHALL always rerun.

Structure
REQ-037 Bypass codes and FSM state encodings SHALL live in shared package cpu_pkg.
REQ-038 A sub-module btn_sync (2-flop synchronizer plus rising-edge detector) SHALL be instantiated once each for go and step.

Verification
REQ-039 Forwarding: MEM stage RW3 = 5 ALU and WB stage RW4 = 5 load, with R1_addr = 5 and use_r1 -> Bypass1 = 01.
REQ-040 Load-use: MemRead2 with RW2 = 8, and R2_addr = 8 with use_r2 -> Bubble = 1, stall_pc = 1, stall_cnt +1.
REQ-041 Register-0 case: RW3 = 0 and R1_addr = 0 -> Bypass1 = 00, Bubble = 0.
REQ-042 Flush versus stall: br_taken together with a load-use -> Bubble_f = 1, stall_pc = 0, flush_cnt +1, stall_cnt unchanged.
REQ-043 Halt and step: SysCall2 & halt_req -> HALT and NewHalt = 0; a step pulse -> exactly 1 cycle NewHalt = 1; then a go pulse -> RUN.
REQ-044 Reset and saturation: reset release -> clear high for exactly 2 cycles; stall_cnt preloaded to 0xFFFF plus a stall -> stays 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: bypass mux codes, control FSM states and
// the forwarding-select helper used for each ID-stage source operand.
package cpu_pkg;

  localparam logic [1:0] BYP_RF     = 2'b00;
  localparam logic [1:0] BYP_MEM    = 2'b01;
  localparam logic [1:0] BYP_WB_ALU = 2'b10;
  localparam logic [1:0] BYP_WB_LD  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  // A MEM-stage load has no data yet, so only a MEM ALU result may forward.
  function automatic logic [1:0] fwd_sel(
    input logic       use_r,
    input logic [4:0] ra,
    input logic       rw3_en,
    input logic       mtr3,
    input logic [4:0] rw3,
    input logic       rw4_en,
    input logic       mtr4,
    input logic [4:0] rw4
  );
    logic [1:0] sel;
    sel = BYP_RF;
    if (use_r && rw3_en && !mtr3 && (rw3 == ra) && (rw3 != 5'd0))
      sel = BYP_MEM;
    else if (use_r && rw4_en && (rw4 == ra) && (rw4 != 5'd0))
      sel = {1'b1, mtr4};
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous
// pushbutton; a held button yields a single one-cycle pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch/jump
// flush, run/halt/single-step control and performance counters.
module hazard_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clear_n,
  input  logic [4:0]  R1_addr,
  input  logic [4:0]  R2_addr,
  input  logic        use_r1,
  input  logic        use_r2,
  input  logic        Jump,
  input  logic        JmpReg,
  input  logic        br_taken,
  input  logic        RegWrite2,
  input  logic        MemRead2,
  input  logic [4:0]  RW2,
  input  logic        RegWrite3,
  input  logic        MemToReg3,
  input  logic [4:0]  RW3,
  input  logic        RegWrite4,
  input  logic        MemToReg4,
  input  logic [4:0]  RW4,
  input  logic        SysCall2,
  input  logic        halt_req,
  input  logic        go,
  input  logic        step,
  output logic [1:0]  Bypass1,
  output logic [1:0]  Bypass2,
  output logic [1:0]  Bypass3,
  output logic [1:0]  Bypass4,
  output logic        Bubble,
  output logic        Bubble_f,
  output logic        stall_pc,
  output logic        NewHalt,
  output logic        clear,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [31:0] cycle_cnt
);

  logic   w_go_rise, w_step_rise;
  logic   w_lu1, w_lu2;
  state_t r_state, w_next;
  logic   r_init_cnt;

  btn_sync u_go_sync   (.clk(clk), .rst_n(clear_n), .i_btn(go),   .o_rise(w_go_rise));
  btn_sync u_step_sync (.clk(clk), .rst_n(clear_n), .i_btn(step), .o_rise(w_step_rise));

  assign Bypass1 = fwd_sel(use_r1, R1_addr, RegWrite3, MemToReg3, RW3, RegWrite4, MemToReg4, RW4);
  assign Bypass2 = fwd_sel(use_r2, R2_addr, RegWrite3, MemToReg3, RW3, RegWrite4, MemToReg4, RW4);
  assign Bypass3 = BYP_RF;
  assign Bypass4 = BYP_RF;

  // Load-use: producer is a load in EX, or a load in MEM whose data is not yet forwardable.
  assign w_lu1 = use_r1 && (R1_addr != 5'd0) &&
                 ((RegWrite2 && MemRead2 && (RW2 == R1_addr)) ||
                  (RegWrite3 && MemToReg3 && (RW3 == R1_addr)));
  assign w_lu2 = use_r2 && (R2_addr != 5'd0) &&
                 ((RegWrite2 && MemRead2 && (RW2 == R2_addr)) ||
                  (RegWrite3 && MemToReg3 && (RW3 == R2_addr)));

  assign Bubble   = w_lu1 | w_lu2;
  assign Bubble_f = br_taken | Jump | JmpReg;
  assign stall_pc = Bubble & ~Bubble_f;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= (r_state == ST_INIT);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt) w_next = ST_RUN;
      ST_RUN:  if (SysCall2 && halt_req) w_next = ST_HALT;
      ST_HALT: begin
        if (w_go_rise)        w_next = ST_RUN;
        else if (w_step_rise) w_next = ST_STEP;
      end
      ST_STEP: w_next = ST_HALT;
      default: w_next = ST_INIT;
    endcase
  end

  always_comb begin
    NewHalt = 1'b0;
    clear   = 1'b0;
    case (r_state)
      ST_INIT: clear   = 1'b1;
      ST_RUN:  NewHalt = 1'b1;
      ST_STEP: NewHalt = 1'b1;
      default: NewHalt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
      cycle_cnt <= 32'd0;
    end else if (NewHalt) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (stall_pc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (Bubble_f && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
